// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator and its host-side interface.
package spi_pkg;
    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // spi_peripheral register map
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/spi_if.sv
// Host request handshake between the bring-up logic and the SPI initiator.
interface spi_if;
    import spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              busy;
    logic              done;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_ready, busy, done
    );
endinterface

// File: rtl/spi_ctrl_timer.sv
// Loadable down-counter shared by all SPI phase and gap timing; holds at zero.
module spi_ctrl_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one 16-bit {rw,addr,data} frame per accepted request, MSB first.
// Optional read capture on CIPO is compiled in with `define SPI_CIPO_EN.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 8
) (
    input  logic  clk,
    input  logic  rst,
    spi_if.slave  bus,
    output logic  sCLK,
    output logic  nCS,
    output logic  COPI
`ifdef SPI_CIPO_EN
    ,
    input  logic              CIPO,
    output logic [DATA_W-1:0] rd_data
`endif
);
    localparam int TMR_MAX = max2(max2(CLK_DIV, CS_SETUP), max2(CS_HOLD, CS_IDLE));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    // Timer counts N-1 down to 0, so a phase lasts exactly N clk cycles.
    localparam logic [TMR_W-1:0] LD_DIV   = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] LD_SETUP = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] LD_HOLD  = TMR_W'(CS_HOLD - 1);
    localparam logic [TMR_W-1:0] LD_IDLE  = TMR_W'(CS_IDLE - 1);

    state_t                  state_q, state_d;
    logic                    phase_hi_q, phase_hi_d;
    logic [3:0]              bit_q, bit_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    sclk_d, ncs_d, copi_d;
    logic                    done_q, done_d;
    logic                    tmr_load;
    logic [TMR_W-1:0]        tmr_val;
    logic                    tmr_zero;

    spi_ctrl_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        phase_hi_d = phase_hi_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        sclk_d     = sCLK;
        ncs_d      = nCS;
        copi_d     = COPI;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = LD_DIV;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d  = SETUP;
                    shift_d  = {bus.req_rw, bus.req_addr, bus.req_data};
                    bit_d    = 4'd0;
                    ncs_d    = 1'b0;
                    copi_d   = bus.req_rw;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d    = SHIFT;
                    phase_hi_d = 1'b1;
                    sclk_d     = 1'b1;
                    tmr_load   = 1'b1;
                end
            end
            SHIFT: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (phase_hi_q) begin
                        // Falling edge: present the next bit; the last bit stays put.
                        phase_hi_d = 1'b0;
                        sclk_d     = 1'b0;
                        if (bit_q != 4'd15) begin
                            shift_d = {shift_q[FRAME_BITS-2:0], shift_q[FRAME_BITS-1]};
                            copi_d  = shift_q[FRAME_BITS-2];
                        end
                    end else if (bit_q == 4'd15) begin
                        state_d = HOLD;
                        tmr_val = LD_HOLD;
                    end else begin
                        bit_d      = bit_q + 4'd1;
                        phase_hi_d = 1'b1;
                        sclk_d     = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_d  = GAP;
                    ncs_d    = 1'b1;
                    copi_d   = 1'b0;
                    done_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_IDLE;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_hi_q <= 1'b0;
            bit_q      <= 4'd0;
            sCLK       <= 1'b0;
            nCS        <= 1'b1;
            COPI       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_hi_q <= phase_hi_d;
            bit_q      <= bit_d;
            sCLK       <= sclk_d;
            nCS        <= ncs_d;
            COPI       <= copi_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

`ifdef SPI_CIPO_EN
    logic [1:0]        cipo_sync;
    logic [DATA_W-1:0] rx_q;

    // Capture on the rising edges of bits 7..0 (bit counter 8..15).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cipo_sync <= 2'b00;
            rx_q      <= '0;
            rd_data   <= '0;
        end else begin
            cipo_sync <= {cipo_sync[0], CIPO};
            if (sclk_d && !sCLK && (bit_d >= 4'd8)) begin
                rx_q <= {rx_q[DATA_W-2:0], cipo_sync[1]};
            end
            if (done_d) begin
                rd_data <= rx_q;
            end
        end
    end
`endif
endmodule
